// File: rtl/sram_responder.sv
// sram_responder: bridges the cache's held-high read/write requests onto an
// external asynchronous SRAM. Each access latches its address (and write
// data), drives the SRAM strobes for a fixed number of wait cycles, and then
// spends one DONE cycle before it returns to IDLE.
module sram_responder #(
    parameter int RD_WAIT = 2,   // read wait cycles, 1..15
    parameter int WR_WAIT = 2    // write wait cycles, 2..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_sram,
    input  logic        wr_sram,
    input  logic [16:0] addr_cpu,
    input  logic [31:0] data_tosram,
    output logic [31:0] data_fromsram,
    output logic        sram_stalled,
    output logic [16:0] sram_addr,
    output logic [31:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [31:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ACC = 2'd1,
        WR_ACC = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The counter counts down to zero, so each access spends WAIT cycles
    // in its access state.
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg,   cnt_next;
    logic [16:0] addr_reg,  addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] rdata_reg, rdata_next;

    // State and datapath registers. A reset clears them at once, so a write
    // that is in flight loses its strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 17'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
        end
    end

    // Next state: start an access from IDLE (a read beats a write), count
    // down the wait cycles, then take one DONE cycle. Requests are not looked
    // at in DONE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (rd_sram) begin
                    addr_next  = addr_cpu;
                    cnt_next   = RD_LOAD;
                    state_next = RD_ACC;
                end else if (wr_sram) begin
                    addr_next  = addr_cpu;
                    wdata_next = data_tosram;
                    cnt_next   = WR_LOAD;
                    state_next = WR_ACC;
                end
            end
            RD_ACC: begin
                if (cnt_reg == 4'd0) begin
                    rdata_next = sram_dq_in;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            WR_ACC: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes and stall. The last write cycle releases we_n and keeps the
    // address and data driven, which gives the SRAM its hold time. The stall
    // is gated by rst_n, so it drops while reset is asserted.
    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_dq_oe   = 1'b0;
        sram_stalled = 1'b0;
        case (state_reg)
            IDLE: begin
                sram_stalled = rst_n & (rd_sram | wr_sram);
            end
            RD_ACC: begin
                sram_ce_n    = 1'b0;
                sram_oe_n    = 1'b0;
                sram_stalled = rst_n;
            end
            WR_ACC: begin
                sram_ce_n    = 1'b0;
                sram_dq_oe   = 1'b1;
                sram_we_n    = (cnt_reg == 4'd0);
                sram_stalled = rst_n;
            end
            default: begin
                sram_stalled = 1'b0;
            end
        endcase
    end

    assign sram_addr     = addr_reg;
    assign sram_dq_out   = wdata_reg;
    assign data_fromsram = rdata_reg;

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder. It contains a behavioural asynchronous SRAM.
// A request-level reference model predicts latency, strobe counts, read data
// and final memory contents for each access.
module tb_sram_responder;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;

    logic        clk;
    logic        rst_n;
    logic        rd_sram;
    logic        wr_sram;
    logic [16:0] addr_cpu;
    logic [31:0] data_tosram;
    logic [31:0] data_fromsram;
    logic        sram_stalled;
    logic [16:0] sram_addr;
    logic [31:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int vectors;
    int miscompares;

    // SRAM array model and the memory image the bench expects to see
    logic [31:0] mem [0:131071];
    logic [31:0] exp_mem [logic [16:0]];
    logic        pre_en;
    logic [16:0] pre_addr;
    logic [31:0] pre_data;

    sram_responder #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_sram       (rd_sram),
        .wr_sram       (wr_sram),
        .addr_cpu      (addr_cpu),
        .data_tosram   (data_tosram),
        .data_fromsram (data_fromsram),
        .sram_stalled  (sram_stalled),
        .sram_addr     (sram_addr),
        .sram_dq_out   (sram_dq_out),
        .sram_dq_oe    (sram_dq_oe),
        .sram_dq_in    (sram_dq_in),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous read: the data is only driven while the chip and output enables are low
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 32'h0;

    // Write while we_n is low, plus a preload port the bench uses to seed contents
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            mem[sram_addr] <= sram_dq_out;
    end

    task automatic preload(input logic [16:0] a, input logic [31:0] v);
        pre_en = 1'b1; pre_addr = a; pre_data = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
        exp_mem[a] = v;
    endtask

    // Run one access from IDLE (call just after a rising edge). drop_at=N drops the
    // request and zeroes addr_cpu after cycle N-1; keep leaves the request high after DONE.
    task automatic run_access(input bit rd, input bit wr, input logic [16:0] a,
                              input logic [31:0] d, input int drop_at, input bit keep);
        int done_k, oe_lo, we_lo, wait_exp;
        logic [31:0] prev_data;
        wait_exp  = rd ? RD_WAIT : WR_WAIT;
        prev_data = data_fromsram;
        done_k = -1; oe_lo = 0; we_lo = 0;
        rd_sram = rd; wr_sram = wr; addr_cpu = a; data_tosram = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (k > 0 && !sram_stalled) begin
                done_k = k;
                break;
            end
            vectors++;
            if (sram_stalled !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_c%0d addr=%h: got %b want 1", k, a, sram_stalled);
            end
            if (k > 0) begin
                vectors++;
                if (sram_addr !== a || (!rd && sram_dq_out !== d)) begin
                    miscompares++;
                    $display("FAIL latched_c%0d: addr %h data %h want %h %h", k, sram_addr, sram_dq_out, a, d);
                end
            end
            @(posedge clk); #1;
            if (drop_at != 0 && k + 1 == drop_at) begin
                rd_sram = 1'b0; wr_sram = 1'b0; addr_cpu = 17'h0;
            end else begin
                addr_cpu = 17'($urandom);
            end
            data_tosram = $urandom;
        end
        vectors++;
        if (done_k != wait_exp + 1) begin
            miscompares++;
            $display("FAIL done_cycle addr=%h: got %0d want %0d", a, done_k, wait_exp + 1);
        end
        vectors++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
            miscompares++;
            $display("FAIL done_strobes: got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        vectors++;
        if (oe_lo != (rd ? RD_WAIT : 0) || we_lo != (rd ? 0 : WR_WAIT - 1)) begin
            miscompares++;
            $display("FAIL strobe_counts addr=%h: oe_lo %0d we_lo %0d want %0d %0d",
                     a, oe_lo, we_lo, rd ? RD_WAIT : 0, rd ? 0 : WR_WAIT - 1);
        end
        if (!rd) exp_mem[a] = d;
        vectors++;
        if (data_fromsram !== (rd ? exp_mem[a] : prev_data)) begin
            miscompares++;
            $display("FAIL read_data addr=%h: got %h want %h", a, data_fromsram, rd ? exp_mem[a] : prev_data);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem[a] !== exp_mem[a]) begin
            miscompares++;
            $display("FAIL mem_contents addr=%h: got %h want %h", a, mem[a], exp_mem[a]);
        end
        $display("access rd=%0b wr=%0b addr=%h data=%h done@%0d rdata=%h", rd, wr, a, d, done_k, data_fromsram);
        if (!keep) begin
            rd_sram = 1'b0; wr_sram = 1'b0;
            @(negedge clk);
            vectors++;
            if (sram_stalled !== 1'b0 || sram_ce_n !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_after_done: stalled %b ce_n %b want 0 1", sram_stalled, sram_ce_n);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rd_sram = 1'b1; wr_sram = 1'b0;
        addr_cpu = 17'h1234; data_tosram = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_stalled} !== 5'b11100 ||
            data_fromsram !== 32'h0 || sram_addr !== 17'h0 || sram_dq_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: strobes %b data %h addr %h dq %h",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_stalled}, data_fromsram, sram_addr, sram_dq_out);
        end
        rd_sram = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset check done");
    endtask

    task automatic test_read;
        preload(17'h00A5, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 17'h00A5, 32'h0, 0, 1'b0);
    endtask

    task automatic test_write;
        preload(17'h1FFFF, 32'h0);
        run_access(1'b0, 1'b1, 17'h1FFFF, 32'h12345678, 0, 1'b0);
    endtask

    task automatic test_simultaneous;
        preload(17'h0BEEF, 32'hCAFEF00D);
        run_access(1'b1, 1'b1, 17'h0BEEF, 32'h55555555, 0, 1'b0);
    endtask

    task automatic test_drop_write;
        preload(17'h00000, 32'hA0A0A0A0);
        preload(17'h0F00D, 32'h0);
        run_access(1'b0, 1'b1, 17'h0F00D, 32'h87654321, 2, 1'b0);
        vectors++;
        if (mem[0] !== exp_mem[17'h0]) begin
            miscompares++;
            $display("FAIL drop_addr0_untouched: got %h want %h", mem[0], exp_mem[17'h0]);
        end
    endtask

    task automatic test_reset_mid_write;
        preload(17'h02222, 32'h11112222);
        wr_sram = 1'b1; addr_cpu = 17'h02222; data_tosram = 32'h99998888;
        @(posedge clk); #1;
        rst_n = 1'b0; wr_sram = 1'b0;
        #1;
        vectors++;
        if (sram_we_n !== 1'b1 || sram_stalled !== 1'b0 || sram_ce_n !== 1'b1 ||
            sram_dq_oe !== 1'b0 || data_fromsram !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_write: we_n %b stalled %b ce_n %b oe %b data %h",
                     sram_we_n, sram_stalled, sram_ce_n, sram_dq_oe, data_fromsram);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (sram_stalled !== 1'b0 || sram_ce_n !== 1'b1) begin
                miscompares++;
                $display("FAIL idle_after_reset_c%0d: stalled %b ce_n %b", i, sram_stalled, sram_ce_n);
            end
        end
        vectors++;
        if (mem[17'h02222] !== exp_mem[17'h02222]) begin
            miscompares++;
            $display("FAIL reset_no_write: got %h want %h", mem[17'h02222], exp_mem[17'h02222]);
        end
        @(posedge clk); #1;
        $display("reset mid-write checked");
    endtask

    task automatic test_back_to_back;
        preload(17'h00111, 32'h01010101);
        preload(17'h00222, 32'h02020202);
        run_access(1'b1, 1'b0, 17'h00111, 32'h0, 0, 1'b1);
        run_access(1'b1, 1'b0, 17'h00222, 32'h0, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            logic [16:0] a;
            logic [31:0] d;
            bit rd, wr;
            int drop;
            a    = 17'($urandom);
            d    = $urandom;
            rd   = 1'($urandom);
            wr   = rd ? 1'($urandom) : 1'b1;
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (!exp_mem.exists(a)) preload(a, $urandom);
            run_access(rd, wr, a, d, drop, 1'b0);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        pre_en = 1'b0; pre_addr = 17'h0; pre_data = 32'h0;
        rd_sram = 1'b0; wr_sram = 1'b0; addr_cpu = 17'h0; data_tosram = 32'h0;
        rst_n = 1'b0;
        test_reset;
        test_read;
        test_write;
        test_simultaneous;
        test_drop_write;
        test_reset_mid_write;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter RD_WAIT, default 2, SRAM read wait cycles (legal range 1-15).
REQ-002 Parameter WR_WAIT, default 2, SRAM write wait cycles (legal range 2-15).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Ports: clk  in  1  rising-edge clock shared with the cache controller.
REQ-005 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: rd_sram  in  1  read request, held high by the cache for the whole miss.
REQ-007 Ports: wr_sram  in  1  write request, held high by the cache for the whole store.
REQ-008 Ports: addr_cpu  in  17  word address of the request.
REQ-009 Ports: data_tosram  in  32  write data from the cache.
REQ-010 Ports: data_fromsram  out  32  registered read data returned to the cache.
REQ-011 Ports: sram_stalled  out  1  high while the access is incomplete; low means done or idle.
REQ-012 Ports: sram_addr  out  17  address to the external asynchronous SRAM.
REQ-013 Ports: sram_dq_out  out  32  write data driven to the SRAM.
REQ-014 Ports: sram_dq_oe  out  1  high enables the sram_dq_out drivers.
REQ-015 Ports: sram_dq_in  in  32  data read back from the SRAM.
REQ-016 Ports: sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-017 The FSM SHALL have four states, IDLE, RD_ACC, WR_ACC and DONE, plus a 4-bit wait counter.
REQ-018 In IDLE with rd_sram=1, the block SHALL latch addr_cpu, load the counter with RD_WAIT-1 and go to RD_ACC.
REQ-019 In IDLE with wr_sram=1 and rd_sram=0, the block SHALL latch addr_cpu and data_tosram, load the counter with WR_WAIT-1 and go to WR_ACC.
REQ-020 When rd_sram and wr_sram are both high, the read SHALL win; the write is not performed in that cycle.
REQ-021 sram_stalled SHALL be combinational: (IDLE & (rd_sram|wr_sram)) | RD_ACC | WR_ACC; it SHALL be 0 in DONE and in an idle IDLE.
REQ-022 In RD_ACC, sram_ce_n and sram_oe_n SHALL be 0, sram_we_n SHALL be 1, sram_dq_oe SHALL be 0, and the counter SHALL decrement each cycle.
REQ-023 At the RD_ACC edge where the counter is 0, the block SHALL register sram_dq_in into data_fromsram and go to DONE.
REQ-024 In WR_ACC, sram_ce_n and sram_dq_oe SHALL be 0 and 1 respectively, sram_oe_n SHALL be 1, and sram_we_n SHALL be 0 except in the final cycle (counter=0), which gives address/data hold.
REQ-025 At the WR_ACC edge where the counter is 0, the FSM SHALL go to DONE.
REQ-026 DONE SHALL last exactly one cycle, with all strobes inactive, then return unconditionally to IDLE.
REQ-027 Read latency SHALL be: request seen at cycle 0, sram_stalled high for cycles 0..RD_WAIT, DONE (stalled=0, data valid) at cycle RD_WAIT+1.
REQ-028 Write latency SHALL be: sram_stalled high for cycles 0..WR_WAIT, DONE at cycle WR_WAIT+1.
REQ-029 data_fromsram SHALL hold its value until the next read capture; writes SHALL NOT alter it.
REQ-030 sram_addr and sram_dq_out SHALL come from the latched registers and SHALL be stable for the whole access, regardless of changes on addr_cpu or data_tosram.
REQ-031 If the request drops mid-access, the access SHALL still complete, with DONE pulsed once; a write is never truncated.
REQ-032 A request still high in DONE SHALL be ignored; a request high in IDLE after DONE SHALL start a new access.

Reset
REQ-033 While rst_n=0, regardless of clock, the block SHALL force state=IDLE and counter=0.
REQ-034 While rst_n=0, the block SHALL force sram_ce_n, sram_oe_n and sram_we_n to 1, and sram_dq_oe to 0.
REQ-035 While rst_n=0, the block SHALL force data_fromsram, sram_addr and sram_dq_out to 0, and sram_stalled to 0.
REQ-036 A reset asserted mid-write SHALL deassert sram_we_n immediately, with no further SRAM cycle after release.

Verification
REQ-037 Read, RD_WAIT=2: rd_sram=1, addr_cpu=0x00A5, SRAM model returns 0xDEADBEEF -> sram_stalled=1 for cycles 0-2, cycle 3 stalled=0 and data_fromsram=0xDEADBEEF, sram_oe_n low for exactly 2 cycles.
REQ-038 Write, WR_WAIT=2: wr_sram=1, addr_cpu=0x1FFFF, data_tosram=0x12345678 -> sram_we_n low for 1 cycle, high in the hold cycle, DONE at cycle 3, model location 0x1FFFF=0x12345678.
REQ-039 Simultaneous rd_sram=wr_sram=1 -> read performed, sram_we_n never low, data_fromsram updated.
REQ-040 Request dropped after cycle 1 of a write, with addr_cpu changed to 0x00000 -> write completes to the original address, DONE pulses once.
REQ-041 rst_n pulled low in WR_ACC cycle 1 -> sram_we_n=1 and sram_stalled=0 in the same cycle; after release with no request, FSM stays IDLE.
REQ-042 Back-to-back: rd_sram held through DONE, then a new address in IDLE -> second read starts the cycle after DONE, and no read is missed or duplicated.
